// File: rtl/init_if.sv
// Handshake bundle between the init request producer, the init block and the
// traversal request consumer. The master drives init requests and consumes
// traversal requests. The slave (the init block) does the opposite.
interface init_if #(
  parameter int RID_WIDTH = 8
) ();
  localparam int INIT_REQ_WIDTH = 352 + RID_WIDTH;
  localparam int TRV_REQ_WIDTH  = 448 + RID_WIDTH;

  logic [INIT_REQ_WIDTH-1:0] init_req_stream_rsc_dat;
  logic                      init_req_stream_rsc_vld;
  logic                      init_req_stream_rsc_rdy;
  logic [TRV_REQ_WIDTH-1:0]  trv_req_stream_rsc_dat;
  logic                      trv_req_stream_rsc_vld;
  logic                      trv_req_stream_rsc_rdy;

  modport slave (
    input  init_req_stream_rsc_dat, init_req_stream_rsc_vld,
    output init_req_stream_rsc_rdy,
    output trv_req_stream_rsc_dat, trv_req_stream_rsc_vld,
    input  trv_req_stream_rsc_rdy
  );

  modport master (
    output init_req_stream_rsc_dat, init_req_stream_rsc_vld,
    input  init_req_stream_rsc_rdy,
    input  trv_req_stream_rsc_dat, trv_req_stream_rsc_vld,
    output trv_req_stream_rsc_rdy
  );
endinterface

// File: rtl/init.sv
// Ray init stage. It accepts one ray, computes the FP32 reciprocal of each
// direction component with a bit-serial restoring divider (one lane per
// axis), and emits the ray with inv_dir appended as words 11-13.

// One reciprocal lane. The divider computes 1.0 / 1.m one quotient bit per
// step. After 26 steps, inv holds the packed FP32 result. The 26th quotient
// bit comes straight from the combinational next-state, so inv is valid in
// the same cycle as the final step.
module init_rcp_lane (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dir,
  output logic [31:0] inv
);
  logic [24:0] rem, rem_sub, rem_nxt;
  logic [24:0] q;
  logic [25:0] q_nxt;
  logic        ge;
  logic [23:0] m;
  logic [7:0]  e;
  logic signed [9:0] ex;
  logic [22:0] frac;
  logic        grd, sticky, rnd;
  logic [30:0] mag;

  assign m = {1'b1, dir[22:0]};
  assign e = dir[30:23];

  // One restoring-division step, plus normalise, round-to-nearest-even and special cases
  always_comb begin
    ge      = (rem >= {1'b0, m});
    rem_sub = ge ? (rem - {1'b0, m}) : rem;
    rem_nxt = rem_sub << 1;
    q_nxt   = {q, ge};
    sticky  = (rem_nxt != 25'd0);
    // The quotient lies in (0.5, 1]. Bit 25 is set only when the mantissa is exactly 1.0.
    if (q_nxt[25]) begin
      ex     = 10'sd254 - $signed({2'b00, e});
      frac   = q_nxt[24:2];
      grd    = q_nxt[1];
      sticky = sticky | q_nxt[0];
    end else begin
      ex     = 10'sd253 - $signed({2'b00, e});
      frac   = q_nxt[23:1];
      grd    = q_nxt[0];
    end
    rnd = grd & (sticky | frac[0]);
    // A rounding carry out of the fraction bumps the exponent naturally.
    mag = {ex[7:0], frac} + {30'd0, rnd};
    if (e == 8'hFF)
      inv = (dir[22:0] != 23'd0) ? 32'h7FC0_0000 : {dir[31], 31'd0};
    else if (e == 8'h00)
      inv = {dir[31], 8'hFF, 23'd0};
    else if (ex <= 10'sd0)
      inv = {dir[31], 31'd0};
    else
      inv = {dir[31], mag};
  end

  // Divider state: the remainder starts at 1.0 in mantissa scale
  always_ff @(posedge clk or posedge arst_n) begin
    if (arst_n) begin
      rem <= '0;
      q   <= '0;
    end else if (load) begin
      rem <= 25'h080_0000;
      q   <= '0;
    end else if (step) begin
      rem <= rem_nxt;
      q   <= q_nxt[24:0];
    end
  end
endmodule

module init #(
  parameter int RID_WIDTH = 8
) (
  input  logic  clk,
  input  logic  arst_n,
  init_if.slave bus
);
  localparam int INIT_REQ_WIDTH = 352 + RID_WIDTH;
  localparam int TRV_REQ_WIDTH  = 448 + RID_WIDTH;
  localparam int NUM_LANES      = 3;
  localparam logic [4:0] LAST_STEP = 5'd25;

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t                          state;
  logic [4:0]                      cnt;
  logic [INIT_REQ_WIDTH-1:0]       req_q;
  logic [TRV_REQ_WIDTH-1:0]        trv_q;
  logic                            rdy_q, vld_q;
  logic                            accept, step;
  logic [NUM_LANES-1:0][31:0]      inv;

  assign accept = (state == IDLE) & rdy_q & bus.init_req_stream_rsc_vld;
  assign step   = (state == CALC);

  assign bus.init_req_stream_rsc_rdy = rdy_q;
  assign bus.trv_req_stream_rsc_vld  = vld_q;
  assign bus.trv_req_stream_rsc_dat  = trv_q;

  // Direction words 3..5 feed one reciprocal lane each
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    init_rcp_lane u_lane (
      .clk    (clk),
      .arst_n (arst_n),
      .load   (accept),
      .step   (step),
      .dir    (req_q[RID_WIDTH + 32*(3+g) +: 32]),
      .inv    (inv[g])
    );
  end

  // Control FSM: accept, then 26 divider steps with the result registered on the last one, then hold until taken
  always_ff @(posedge clk or posedge arst_n) begin
    if (arst_n) begin
      state <= IDLE;
      cnt   <= '0;
      req_q <= '0;
      trv_q <= '0;
      rdy_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_q <= bus.init_req_stream_rsc_dat;
            cnt   <= '0;
            rdy_q <= 1'b0;
            state <= CALC;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        CALC: begin
          cnt <= cnt + 5'd1;
          if (cnt == LAST_STEP) begin
            trv_q <= {inv, req_q};
            vld_q <= 1'b1;
            state <= OUT;
          end
        end
        OUT: begin
          if (bus.trv_req_stream_rsc_rdy) begin
            vld_q <= 1'b0;
            rdy_q <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_init.sv
// Directed and random checks for the ray init stage.
module tb_init;
  localparam int RW = 8;
  localparam int IW = 352 + RW;
  localparam int TW = 448 + RW;
  localparam int NRND = 1000;

  logic clk = 1'b0;
  logic arst_n = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  init_if #(.RID_WIDTH(RW)) bus ();
  init #(.RID_WIDTH(RW)) dut (.clk(clk), .arst_n(arst_n), .bus(bus));

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic [7:0] rid, input logic [31:0] dx, dy, dz,
                                       input logic [31:0] base);
    logic [IW-1:0] r;
    r = '0;
    r[RW-1:0] = rid;
    for (int k = 0; k < 11; k++) r[RW + 32*k +: 32] = base + 32'(k) * 32'h0101_0101;
    r[RW + 96 +: 32]  = dx;
    r[RW + 128 +: 32] = dy;
    r[RW + 160 +: 32] = dz;
    return r;
  endfunction

  // Reference reciprocal: one wide integer divide, then normalise and round.
  function automatic logic [31:0] rcp(input logic [31:0] d);
    logic [95:0] num, den, q, r;
    logic [22:0] f;
    logic        g, st;
    logic [30:0] mag;
    int          be;
    if (d[30:23] == 8'hFF) return (d[22:0] != 0) ? 32'h7FC0_0000 : {d[31], 31'd0};
    if (d[30:23] == 8'h00) return {d[31], 8'hFF, 23'd0};
    num = 96'd1 << 70;
    den = {72'd0, 1'b1, d[22:0]};
    q = num / den;
    r = num % den;
    if (q[47]) begin
      be = 254 - int'(d[30:23]); f = '0; g = 1'b0; st = 1'b0;
    end else begin
      be = 253 - int'(d[30:23]); f = q[45:23]; g = q[22]; st = (q[21:0] != 0) || (r != 0);
    end
    if (be <= 0) return {d[31], 31'd0};
    mag = {be[7:0], f} + {30'd0, (g && (st || f[0]))};
    return {d[31], mag};
  endfunction

  // Present req until accepted. Returns just after the accept edge, with vld still asserted.
  task automatic send(input logic [IW-1:0] req, output int acc, output bit ok);
    ok = 1'b0; acc = 0;
    bus.init_req_stream_rsc_dat = req;
    bus.init_req_stream_rsc_vld = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (bus.init_req_stream_rsc_rdy) begin
        @(posedge clk); #1;
        acc = cyc; ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  // Wait for trv vld, capture it, and let one transfer happen (trv rdy must be 1).
  task automatic recv(output logic [TW-1:0] d, output int vc, output bit ok);
    ok = 1'b0; vc = 0; d = '0;
    for (int i = 0; i < 200; i++) begin
      if (bus.trv_req_stream_rsc_vld) begin
        vc = cyc; ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("recv_timeout", 0, 1);
      return;
    end
    d = bus.trv_req_stream_rsc_dat;
    @(posedge clk); #1;
  endtask

  // vld rises 26 edges after the accept edge (the 27th cycle of the request),
  // which together with one transfer edge and one idle edge gives a 28-cycle period.
  task automatic run_dir(input string tag, input logic [IW-1:0] req, input logic [31:0] ix, iy, iz);
    int acc, vc;
    bit ok;
    logic [TW-1:0] d;
    send(req, acc, ok);
    bus.init_req_stream_rsc_vld = 1'b0;
    if (ok) begin
      recv(d, vc, ok);
      if (ok) begin
        chk({tag, "_ix"}, d[IW +: 32], ix);
        chk({tag, "_iy"}, d[IW+32 +: 32], iy);
        chk({tag, "_iz"}, d[IW+64 +: 32], iz);
        chk({tag, "_echo"}, d[IW-1:0], req);
        chk({tag, "_lat"}, vc - acc, 26);
      end
    end
    @(negedge clk);
  endtask

  logic [IW-1:0] rq  [NRND];
  logic [TW-1:0] exq [NRND];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IW-1:0] req;
    logic [TW-1:0] d0;
    int acc, cnt;
    bit ok;

    bus.init_req_stream_rsc_dat = '0;
    bus.init_req_stream_rsc_vld = 1'b0;
    bus.trv_req_stream_rsc_rdy  = 1'b1;

    // Reset state, independent of clock edges
    #12;
    chk("rst_rdy", bus.init_req_stream_rsc_rdy, 0);
    chk("rst_vld", bus.trv_req_stream_rsc_vld, 0);
    chk("rst_dat", bus.trv_req_stream_rsc_dat, 0);
    @(negedge clk);
    arst_n = 1'b0;
    chk("rel_rdy_pre", bus.init_req_stream_rsc_rdy, 0);
    @(posedge clk); #1;
    chk("rel_rdy", bus.init_req_stream_rsc_rdy, 1);
    @(negedge clk);

    // Directed reciprocals
    run_dir("v_basic", mk(8'h5A, 32'h4000_0000, 32'hC080_0000, 32'h3F00_0000, 32'h1111_0000),
            32'h3F00_0000, 32'hBE80_0000, 32'h4000_0000);
    run_dir("v_zero_nan", mk(8'h01, 32'h0000_0000, 32'h8000_0000, 32'h7FC1_2345, 32'h2222_0000),
            32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
    run_dir("v_inf_sub", mk(8'h02, 32'h7F80_0000, 32'hFF80_0000, 32'h0001_16C2, 32'h3333_0000),
            32'h0000_0000, 32'h8000_0000, 32'h7F80_0000);
    run_dir("v_rne_flush", mk(8'h03, 32'h4040_0000, 32'h7F7F_FFFF, 32'h3F80_0000, 32'h4444_0000),
            32'h3EAA_AAAB, 32'h0000_0000, 32'h3F80_0000);

    // Backpressure: output held 50 cycles while junk sits on the input
    bus.trv_req_stream_rsc_rdy = 1'b0;
    req = mk(8'hB7, 32'h3F80_0000, 32'h4000_0000, 32'hBF00_0000, 32'h5555_0000);
    send(req, acc, ok);
    bus.init_req_stream_rsc_dat = {IW{1'b1}};
    for (int i = 0; i < 40 && !bus.trv_req_stream_rsc_vld; i++) @(negedge clk);
    chk("bp_vld_rise", bus.trv_req_stream_rsc_vld, 1);
    d0 = bus.trv_req_stream_rsc_dat;
    chk("bp_word", d0, {32'hC000_0000, 32'h3F00_0000, 32'h3F80_0000, req});
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("bp_vld", bus.trv_req_stream_rsc_vld, 1);
      chk("bp_dat", bus.trv_req_stream_rsc_dat, d0);
      chk("bp_rdy", bus.init_req_stream_rsc_rdy, 0);
    end
    bus.init_req_stream_rsc_vld = 1'b0;
    bus.trv_req_stream_rsc_rdy  = 1'b1;
    @(posedge clk); #1;
    chk("bp_taken", bus.trv_req_stream_rsc_vld, 0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.trv_req_stream_rsc_vld) cnt++;
    end
    chk("bp_dup", cnt, 0);

    // Reset in the middle of CALC discards the request
    send(mk(8'hC1, 32'h4040_0000, 32'h4040_0000, 32'h4040_0000, 32'h6666_0000), acc, ok);
    bus.init_req_stream_rsc_vld = 1'b0;
    repeat (10) @(negedge clk);
    #2 arst_n = 1'b1;
    #1;
    chk("rc_vld", bus.trv_req_stream_rsc_vld, 0);
    chk("rc_rdy", bus.init_req_stream_rsc_rdy, 0);
    repeat (2) @(negedge clk);
    arst_n = 1'b0;
    @(posedge clk); #1;
    chk("rc_rdy_rel", bus.init_req_stream_rsc_rdy, 1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.trv_req_stream_rsc_vld) cnt++;
    end
    chk("rc_no_out", cnt, 0);
    run_dir("v_after_rst", mk(8'h77, 32'h4080_0000, 32'hC000_0000, 32'h3E80_0000, 32'h7777_0000),
            32'h3E80_0000, 32'hBF00_0000, 32'h4080_0000);

    // Reset while holding OUT drops vld and data at once
    bus.trv_req_stream_rsc_rdy = 1'b0;
    send(mk(8'h99, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h8888_0000), acc, ok);
    bus.init_req_stream_rsc_vld = 1'b0;
    for (int i = 0; i < 40 && !bus.trv_req_stream_rsc_vld; i++) @(negedge clk);
    chk("ro_vld_rise", bus.trv_req_stream_rsc_vld, 1);
    #2 arst_n = 1'b1;
    #1;
    chk("ro_vld", bus.trv_req_stream_rsc_vld, 0);
    chk("ro_dat", bus.trv_req_stream_rsc_dat, 0);
    @(negedge clk);
    arst_n = 1'b0;
    bus.trv_req_stream_rsc_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("ro_no_out", bus.trv_req_stream_rsc_vld, 0);

    // Random normal directions, back-to-back with vld and trv rdy held high
    for (int i = 0; i < NRND; i++) begin
      logic [IW-1:0] r;
      logic [31:0] w;
      logic [7:0] e;
      r = '0;
      r[RW-1:0] = 8'($urandom);
      for (int k = 0; k < 11; k++) r[RW + 32*k +: 32] = $urandom;
      for (int k = 3; k < 6; k++) begin
        w = $urandom;
        e = 8'($urandom_range(1, 254));
        r[RW + 32*k +: 32] = {w[31], e, w[22:0]};
      end
      rq[i]  = r;
      exq[i] = {rcp(r[RW+160 +: 32]), rcp(r[RW+128 +: 32]), rcp(r[RW+96 +: 32]), r};
    end
    @(negedge clk);
    fork
      begin : drv
        int a, a_prev;
        bit k_ok;
        a_prev = 0;
        for (int i = 0; i < NRND; i++) begin
          send(rq[i], a, k_ok);
          if (!k_ok) break;
          if (i > 0) chk("rnd_period", a - a_prev, 28);
          a_prev = a;
        end
        bus.init_req_stream_rsc_vld = 1'b0;
      end
      begin : mon
        logic [TW-1:0] d;
        int v;
        bit m_ok;
        for (int i = 0; i < NRND; i++) begin
          recv(d, v, m_ok);
          if (!m_ok) break;
          chk("rnd_dat", d, exq[i]);
        end
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/init.md
INIT -- requirements
Module: init

Interface
REQ-001 SHALL have parameter RID_WIDTH, default 8, request-ID width carried in the LSBs of both streams.
REQ-002 SHALL have derived widths INIT_REQ_WIDTH = 352+RID_WIDTH and TRV_REQ_WIDTH = 448+RID_WIDTH.
REQ-003 SHALL use one clock and an asynchronous, active-high reset; clk and arst_n are named as in the codebase.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 arst_n  input  1  asynchronous reset, active-high (asserted at 1) despite the name.
REQ-006 init_req_stream_rsc_dat  input  INIT_REQ_WIDTH  init request.
REQ-007 init_req_stream_rsc_vld  input  1  init request valid.
REQ-008 init_req_stream_rsc_rdy  output  1  init request ready.
REQ-009 trv_req_stream_rsc_dat  output  TRV_REQ_WIDTH  traversal request.
REQ-010 trv_req_stream_rsc_vld  output  1  traversal request valid.
REQ-011 trv_req_stream_rsc_rdy  input  1  downstream ready.

Function
REQ-012 Field layout SHALL be: rid = dat[RID_WIDTH-1:0]; 32-bit word k = dat[RID_WIDTH+32k +: 32].
REQ-013 Init words SHALL be: 0-2 origin x/y/z, 3-5 dir x/y/z, 6 tmin, 7 tmax, 8-10 opaque aux; all FP32 except aux.
REQ-014 Trv output words 0-10 and rid SHALL equal the accepted init request bit-exactly.
REQ-015 Trv words 11-13 SHALL be inv_dir x/y/z = 1.0/dir, FP32, round-to-nearest-even.
REQ-016 Zero or subnormal dir SHALL give a same-signed infinity (0x7F800000 / 0xFF800000).
REQ-017 ±inf dir SHALL give ±0; any NaN dir SHALL give 0x7FC00000.
REQ-018 Results below the normal range SHALL flush to a same-signed zero; no overflow exists for normal inputs.
REQ-019 An init transfer SHALL occur on a rising clk edge with init vld=1 and rdy=1; a trv transfer SHALL occur on an edge with trv vld=1 and rdy=1.
REQ-020 State machine SHALL be IDLE -> CALC -> OUT -> IDLE.
REQ-021 In IDLE, rdy=1; an accepted request SHALL be latched and the state SHALL go to CALC.
REQ-022 CALC SHALL run three parallel iterative mantissa dividers for exactly 26 cycles, then go to OUT.
REQ-023 In OUT, trv vld=1 with stable dat until transferred; transfer SHALL return to IDLE.
REQ-024 Latency from the init transfer edge to the first cycle with trv vld=1 SHALL be 27 cycles.
REQ-025 Throughput SHALL be one request per 28 cycles with trv rdy held at 1.
REQ-026 init rdy SHALL be 0 outside IDLE; input vld and dat SHALL be ignored while rdy=0.
REQ-027 Backpressure (trv rdy=0) SHALL hold OUT indefinitely with no data loss or change.
REQ-028 Requests SHALL be processed strictly in order, with no reordering and no dropped or duplicated requests.

Reset
REQ-029 While arst_n=1, the state SHALL be IDLE, init rdy=0, trv vld=0, and trv dat=0, regardless of clk.
REQ-030 After release, init rdy SHALL rise on the first rising clk edge.
REQ-031 Reset mid-CALC or mid-OUT SHALL discard the in-flight request, and no trv transfer for it SHALL occur.

Verification
REQ-032 dir=(2.0,-4.0,0.5), rid=0x5A -> words 11-13 = 0x3F000000, 0xBE800000, 0x40000000; words 0-10 and rid echoed; vld 27 cycles after accept.
REQ-033 dir=(+0,-0,NaN) -> inv_dir = 0x7F800000, 0xFF800000, 0x7FC00000; dir=(+inf,-inf,1e-40) -> 0x00000000, 0x80000000, 0x7F800000.
REQ-034 dir=3.0 -> 0x3EAAAAAB (RNE); dir=0x7F7FFFFF -> 0x00000000 (flush).
REQ-035 Constant vld=1 and trv rdy=1 with 1000 random normal requests -> all outputs match a golden model in order, one every 28 cycles.
REQ-036 trv rdy=0 for 50 cycles during OUT -> vld stays 1, dat stable, init rdy=0; single transfer when rdy returns.
REQ-037 arst_n pulsed during CALC -> vld=0 immediately, init rdy=1 after release, next request processed correctly.
